// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS memory stage: access sizes, controller states
// and response error codes. Byte_Control imports the same size encodings.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request, data-memory and response signals of the memory-stage controller.
// slave = the controller, master = the pipeline and memory around it.
interface mem_access_ctrl_if #(parameter int RD_W = 5);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [RD_W-1:0] req_rd;

  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [3:0]      mem_be;
  logic [31:0]     mem_wdata;
  logic            mem_ack;
  logic [31:0]     mem_rdata;

  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic [1:0]      rsp_size;
  logic [RD_W-1:0] rsp_rd;
  logic [1:0]      rsp_err;

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, req_rd,
    input  mem_ack, mem_rdata,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output rsp_valid, rsp_data, rsp_size, rsp_rd, rsp_err
  );

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, req_rd,
    output mem_ack, mem_rdata,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  rsp_valid, rsp_data, rsp_size, rsp_rd, rsp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store-data replication, misalignment
// check for the incoming request, and shift/mask of returned load data.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_aligned
);

  logic [31:0] rdata_shifted;

  always_comb begin
    be         = 4'b1111;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SIZE_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      // size 3 behaves exactly like a word
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

  always_comb begin
    rdata_shifted = rdata >> {rd_addr_lo, 3'b000};
    case (rd_size)
      SIZE_BYTE: rdata_aligned = {24'h0, rdata_shifted[7:0]};
      SIZE_HALF: rdata_aligned = {16'h0, rdata_shifted[15:0]};
      default:   rdata_aligned = rdata_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: one request at a time over a req/ack
// data-memory port, with misalignment and ack-timeout error responses.
//
//   state  | meaning
//   IDLE   | ready for a request; latches it on req_valid
//   ACCESS | mem_req held until ack or timeout
//   RESP   | one cycle; rsp_valid pulses for loads and errors
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int RD_W    = 5
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_ctrl_if.slave  bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_INIT = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state_q, state_d;
  logic            we_q;
  logic [1:0]      size_q;
  logic [1:0]      addr_lo_q;
  logic [RD_W-1:0] rd_q;
  logic [31:0]     mem_addr_q;
  logic [3:0]      mem_be_q;
  logic [31:0]     mem_wdata_q;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            rsp_pend_q;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [1:0]      rsp_size_q, rsp_size_d;
  logic [RD_W-1:0] rsp_rd_q, rsp_rd_d;
  logic [1:0]      rsp_err_q, rsp_err_d;

  logic            accept;
  logic            rsp_upd;
  logic [3:0]      be_c;
  logic [31:0]     wdata_c;
  logic            misaligned_c;
  logic [31:0]     rdata_c;

  mem_lane_align u_lane (
    .size          (bus.req_size),
    .addr_lo       (bus.req_addr[1:0]),
    .wdata         (bus.req_wdata),
    .be            (be_c),
    .wdata_rep     (wdata_c),
    .misaligned    (misaligned_c),
    .rd_size       (size_q),
    .rd_addr_lo    (addr_lo_q),
    .rdata         (bus.mem_rdata),
    .rdata_aligned (rdata_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    rsp_upd    = 1'b0;
    rsp_data_d = '0;
    rsp_size_d = size_q;
    rsp_rd_d   = rd_q;
    rsp_err_d  = ERR_NONE;
    tmr_d      = tmr_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          tmr_d  = TMR_INIT;
          if (misaligned_c) begin
            state_d    = RESP;
            rsp_upd    = 1'b1;
            rsp_size_d = bus.req_size;
            rsp_rd_d   = bus.req_rd;
            rsp_err_d  = ERR_ALIGN;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // ack is checked first so an ack on the last allowed cycle still wins
        if (bus.mem_ack) begin
          state_d    = RESP;
          rsp_upd    = !we_q;
          rsp_data_d = rdata_c;
        end else if ((TIMEOUT != 0) && (tmr_q == '0)) begin
          state_d   = RESP;
          rsp_upd   = 1'b1;
          rsp_err_d = ERR_TIMEOUT;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      size_q      <= '0;
      addr_lo_q   <= '0;
      rd_q        <= '0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      tmr_q       <= '0;
      rsp_pend_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_size_q  <= '0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= '0;
    end else begin
      tmr_q      <= tmr_d;
      rsp_pend_q <= rsp_upd;
      if (accept) begin
        we_q        <= bus.req_we;
        size_q      <= bus.req_size;
        addr_lo_q   <= bus.req_addr[1:0];
        rd_q        <= bus.req_rd;
        mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
        mem_be_q    <= be_c;
        mem_wdata_q <= wdata_c;
      end
      if (rsp_upd) begin
        rsp_data_q <= rsp_data_d;
        rsp_size_q <= rsp_size_d;
        rsp_rd_q   <= rsp_rd_d;
        rsp_err_q  <= rsp_err_d;
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_req   = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = (state_q == RESP) && rsp_pend_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_size  = rsp_size_q;
  assign bus.rsp_rd    = rsp_rd_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage load/store controller for the MIPS datapath.
- Accepts one load/store request from the EX/MEM pipeline register.
- Drives a word-wide data memory port using a req/ack handshake, with byte enables and replicated write data.
- For loads, returns the read data right-justified and zero-padded, along with the unchanged size code. The sign-extension (Byte_Control) stage directly downstream consumes both.
- Also flags misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT, default 16: cycles waiting for mem_ack before a bus error. 0 disables the timeout.
- RD_W, default 5: width of the destination-register tag.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 word, 1 half, 2 byte, 3 treated as word
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_rd  in  RD_W  load destination tag
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write strobe
- mem_addr  out  32  word address ({req_addr[31:2],2'b00})
- mem_be  out  4  byte enables, little-endian lanes
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion
- mem_rdata  in  32  read data, valid with mem_ack
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  32  aligned load data, upper bits zero
- rsp_size  out  2  copy of req_size, goes to the ByteControl input
- rsp_rd  out  RD_W  copy of req_rd
- rsp_err  out  2  0 ok, 1 misaligned, 2 timeout

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; req_ready 1; all other outputs 0. Reset asserted mid-access drops mem_req immediately and discards the pending response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch all request fields.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with err=1. No memory access occurs.
  - Aligned request: go to ACCESS.
- ACCESS:
  - mem_req = 1.
  - mem_addr, mem_be, mem_we and mem_wdata are registered and stay stable until ack.
  - mem_ack:
    - Load: capture mem_rdata >> (8*addr[1:0]), masked to the access size.
    - Store: no data captured.
    - Go to RESP, err=0.
  - Timeout counter: counts cycles in ACCESS. Reaching TIMEOUT with no ack → mem_req drops, go to RESP with err=2, rsp_data=0.
  - Ack and timeout in the same cycle: ack wins.
- RESP:
  - Lasts exactly one cycle, then returns to IDLE.
  - rsp_valid pulses if the access was a load or err!=0. A successful store produces no pulse.
  - rsp_data, rsp_size, rsp_rd and rsp_err hold their values until the next response.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: addr[1]=0 → 0011, addr[1]=1 → 1100
  - word: 1111
- Write data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata unchanged
- Latency: accept in cycle N; mem_req high at N+1. An ack in cycle M gives rsp_valid at M+1 and req_ready at M+2. Zero-wait memory gives 3 cycles per access.
- mem_ack outside ACCESS is ignored. req_valid outside IDLE is ignored; the pipeline must stall while req_ready=0.

Decomposition:
- Package mips_mem_pkg holds:
  - size localparams SIZE_WORD=0, SIZE_HALF=1, SIZE_BYTE=2
  - state enum {IDLE, ACCESS, RESP}
  - error codes ERR_NONE, ERR_ALIGN, ERR_TIMEOUT
  - Byte_Control imports the same size encodings.
- Sub-module mem_lane_align: purely combinational generation of be, replicated wdata, read-data shift/mask and the misalignment check. The FSM, counter and registers stay in the top module.

Test Plan:
- Load byte, addr 0x103, mem_rdata 0xAB000000, ack after 2 cycles → mem_be=1000, mem_addr=0x100; rsp_valid 1 pulse, rsp_data=0x000000AB, rsp_size=2, rsp_err=0.
- Store half 0x1234ABCD to addr 0x202, zero-wait ack → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD; no rsp_valid; req_ready high 3 cycles after accept.
- Load word at addr 0x6 → no mem_req ever asserted; next cycle rsp_valid, rsp_err=1, rsp_data=0.
- Load word with mem_ack never asserted, TIMEOUT=16 → mem_req high exactly 16 cycles, then rsp_err=2; a second request is accepted afterwards.
- mem_ack arriving on the final timeout cycle → rsp_err=0 and data captured (ack wins).
- rst_n pulled low during ACCESS → mem_req and rsp_valid drop asynchronously; after release req_ready=1, and a late mem_ack is ignored.
